// File: rtl/midi_status_decoder_if.sv
// Byte-in / decoded-flags-out bundle between the MIDI UART receiver, the decoder and the note stack.
interface midi_status_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       byteready;
    logic [7:0] databyte;
    logic       is_st_note_on;
    logic       is_st_note_off;
    logic       is_st_ctrl;
    logic       is_st_sysex;
    logic       is_data_byte;
    logic       is_velocity;
    logic [3:0] midi_ch;
    logic       rx_overrun;

    modport master (
        output rx_data, rx_valid,
        input  byteready, databyte, is_st_note_on, is_st_note_off, is_st_ctrl, is_st_sysex,
        input  is_data_byte, is_velocity, midi_ch, rx_overrun
    );

    modport slave (
        input  rx_data, rx_valid,
        output byteready, databyte, is_st_note_on, is_st_note_off, is_st_ctrl, is_st_sysex,
        output is_data_byte, is_velocity, midi_ch, rx_overrun
    );
endinterface

// File: rtl/midi_status_decoder.sv
// MIDI byte decoder: running status, sysex framing and data-byte position tracking,
// forwarding each data byte as a fixed-width byteready pulse with stable qualifier flags.
module midi_status_decoder #(
    parameter int unsigned BR_CYCLES = 4
) (
    input logic                 CLOCK_25,
    input logic                 reset_reg_N,
    midi_status_decoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StStrobe, StGap} state_e;

    localparam logic [7:0] CntLoad = 8'(BR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       ovr_q, ovr_d;

    logic       rs_vld_q, rs_vld_d;
    logic       need2_q, need2_d;
    logic       dcnt_q, dcnt_d;
    logic [7:0] db_q, db_d;
    logic       on_q, on_d, off_q, off_d, ctrl_q, ctrl_d, sysex_q, sysex_d;
    logic       dat_q, dat_d, vel_q, vel_d;
    logic [3:0] ch_q, ch_d;

    logic consume;
    logic fwd;

    assign consume = (state_q == StIdle) && pend_vld_q;

    // State register
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (fwd) begin
                    state_d = StStrobe;
                    cnt_d   = CntLoad;
                end
            end
            StStrobe: begin
                if (cnt_q == 8'd0) state_d = StGap;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.byteready      = (state_q == StStrobe);
        bus.databyte       = db_q;
        bus.is_st_note_on  = on_q;
        bus.is_st_note_off = off_q;
        bus.is_st_ctrl     = ctrl_q;
        bus.is_st_sysex    = sysex_q;
        bus.is_data_byte   = dat_q;
        bus.is_velocity    = vel_q;
        bus.midi_ch        = ch_q;
        bus.rx_overrun     = ovr_q;
    end

    // A byte offered in the same cycle the pending slot drains is taken, not dropped.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = ovr_q;
        if (consume) pend_vld_d = 1'b0;
        if (bus.rx_valid) begin
            if (!pend_vld_q || consume) begin
                pend_d     = bus.rx_data;
                pend_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Byte classification; only runs in IDLE, so flags never move while byteready is high.
    always_comb begin
        fwd      = 1'b0;
        rs_vld_d = rs_vld_q;
        need2_d  = need2_q;
        dcnt_d   = dcnt_q;
        db_d     = db_q;
        on_d     = on_q;
        off_d    = off_q;
        ctrl_d   = ctrl_q;
        sysex_d  = sysex_q;
        dat_d    = dat_q;
        vel_d    = vel_q;
        ch_d     = ch_q;
        if (consume) begin
            if (pend_q[7] && (pend_q[7:4] != 4'hF)) begin
                rs_vld_d = 1'b1;
                ch_d     = pend_q[3:0];
                on_d     = (pend_q[7:4] == 4'h9);
                off_d    = (pend_q[7:4] == 4'h8);
                ctrl_d   = (pend_q[7:4] == 4'hB);
                need2_d  = !((pend_q[7:4] == 4'hC) || (pend_q[7:4] == 4'hD));
                dcnt_d   = 1'b0;
                dat_d    = 1'b0;
                vel_d    = 1'b0;
                sysex_d  = 1'b0;
            end else if (pend_q == 8'hF0) begin
                rs_vld_d = 1'b0;
                ch_d     = 4'h0;
                on_d     = 1'b0;
                off_d    = 1'b0;
                ctrl_d   = 1'b0;
                sysex_d  = 1'b1;
            end else if (pend_q == 8'hF7) begin
                sysex_d = 1'b0;
            end else if (pend_q[7] && (pend_q < 8'hF8)) begin
                rs_vld_d = 1'b0;
                ch_d     = 4'h0;
                on_d     = 1'b0;
                off_d    = 1'b0;
                ctrl_d   = 1'b0;
                sysex_d  = 1'b0;
                dat_d    = 1'b0;
                vel_d    = 1'b0;
                dcnt_d   = 1'b0;
            end else if (!pend_q[7]) begin
                if (sysex_q) begin
                    fwd   = 1'b1;
                    db_d  = pend_q;
                    dat_d = 1'b0;
                    vel_d = 1'b0;
                end else if (rs_vld_q) begin
                    fwd  = 1'b1;
                    db_d = pend_q;
                    if (!dcnt_q) begin
                        dat_d  = 1'b1;
                        vel_d  = 1'b0;
                        dcnt_d = need2_q;
                    end else begin
                        dat_d  = 1'b0;
                        vel_d  = 1'b1;
                        dcnt_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
            rs_vld_q   <= 1'b0;
            need2_q    <= 1'b0;
            dcnt_q     <= 1'b0;
            db_q       <= '0;
            on_q       <= 1'b0;
            off_q      <= 1'b0;
            ctrl_q     <= 1'b0;
            sysex_q    <= 1'b0;
            dat_q      <= 1'b0;
            vel_q      <= 1'b0;
            ch_q       <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
            rs_vld_q   <= rs_vld_d;
            need2_q    <= need2_d;
            dcnt_q     <= dcnt_d;
            db_q       <= db_d;
            on_q       <= on_d;
            off_q      <= off_d;
            ctrl_q     <= ctrl_d;
            sysex_q    <= sysex_d;
            dat_q      <= dat_d;
            vel_q      <= vel_d;
            ch_q       <= ch_d;
        end
    end

endmodule

// File: tb/tb_midi_status_decoder.sv
// Directed bench for midi_status_decoder: message-level reference model checked every cycle,
// plus literal spot checks taken from hand-worked byte sequences.
module tb_midi_status_decoder;

    localparam int unsigned BR = 4;

    logic CLOCK_25    = 1'b0;
    logic reset_reg_N = 1'b0;

    midi_status_decoder_if bus ();

    midi_status_decoder #(.BR_CYCLES(BR)) dut (
        .CLOCK_25   (CLOCK_25),
        .reset_reg_N(reset_reg_N),
        .bus        (bus)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic check_en = 1'b0;

    // Reference model: the last status byte seen, plus what the note stack should be shown.
    logic       m_rs_valid;
    logic [7:0] m_status;
    int         m_pos;
    logic       e_br, e_sysex, e_dat, e_vel, e_ovr;
    logic [7:0] e_db;

    function automatic logic [19:0] exp_vec();
        logic [3:0] hi;
        hi = m_status[7:4];
        return {e_br, e_db, m_rs_valid && (hi == 4'h9), m_rs_valid && (hi == 4'h8),
                m_rs_valid && (hi == 4'hB), e_sysex, e_dat, e_vel,
                m_rs_valid ? m_status[3:0] : 4'h0, e_ovr};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.byteready, bus.databyte, bus.is_st_note_on, bus.is_st_note_off, bus.is_st_ctrl,
                bus.is_st_sysex, bus.is_data_byte, bus.is_velocity, bus.midi_ch, bus.rx_overrun};
    endfunction

    task automatic model_reset();
        m_rs_valid = 1'b0;
        m_status   = 8'h00;
        m_pos      = 0;
        e_br = 1'b0; e_sysex = 1'b0; e_dat = 1'b0; e_vel = 1'b0; e_ovr = 1'b0;
        e_db = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic fwd);
        fwd = 1'b0;
        if (b >= 8'hF8) begin
            // realtime: nothing observable changes
        end else if (b == 8'hF0) begin
            m_rs_valid = 1'b0;
            e_sysex    = 1'b1;
        end else if (b == 8'hF7) begin
            e_sysex = 1'b0;
        end else if (b >= 8'hF1) begin
            m_rs_valid = 1'b0; e_sysex = 1'b0; e_dat = 1'b0; e_vel = 1'b0; m_pos = 0;
        end else if (b >= 8'h80) begin
            m_rs_valid = 1'b1; m_status = b; m_pos = 0;
            e_dat = 1'b0; e_vel = 1'b0; e_sysex = 1'b0;
        end else if (e_sysex) begin
            fwd = 1'b1; e_db = b; e_dat = 1'b0; e_vel = 1'b0;
        end else if (m_rs_valid) begin
            fwd  = 1'b1;
            e_db = b;
            if (m_pos == 0) begin
                e_dat = 1'b1; e_vel = 1'b0;
                m_pos = ((m_status[7:4] == 4'hC) || (m_status[7:4] == 4'hD)) ? 0 : 1;
            end else begin
                e_dat = 1'b0; e_vel = 1'b1; m_pos = 0;
            end
        end
    endtask

    always @(negedge CLOCK_25) begin
        if (check_en) begin
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL cycle_outputs at %0t: got %h required %h", $time, dut_vec(), exp_vec());
            end
        end
    end

    logic br_prev = 1'b0;
    always @(negedge CLOCK_25) begin
        if (bus.byteready && !br_prev) pulses++;
        br_prev = bus.byteready;
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One byte, then wait until the decoder is idle again, stepping the model on the spec's timeline.
    task automatic send_byte(input logic [7:0] b);
        logic fwd;
        @(negedge CLOCK_25);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge CLOCK_25);
        #1 bus.rx_valid = 1'b0;
        @(posedge CLOCK_25);
        #1 model_byte(b, fwd);
        e_br = fwd;
        if (fwd) begin
            repeat (BR) @(posedge CLOCK_25);
            #1 e_br = 1'b0;
        end
        repeat (2) @(posedge CLOCK_25);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge CLOCK_25);
        @(negedge CLOCK_25);
        reset_reg_N = 1'b1;
        check_en    = 1'b1;
        chk("reset_outputs", int'(dut_vec()), 0);

        // Note-on with explicit status
        p0 = pulses;
        send_byte(8'h90);
        send_byte(8'h3C);
        chk("t1_db", int'(bus.databyte), 'h3C);
        chk("t1_on", int'(bus.is_st_note_on), 1);
        chk("t1_data", int'(bus.is_data_byte), 1);
        chk("t1_ch", int'(bus.midi_ch), 0);
        send_byte(8'h64);
        chk("t1_vel_db", int'(bus.databyte), 'h64);
        chk("t1_vel", int'(bus.is_velocity), 1);
        chk("t1_pulses", pulses - p0, 2);

        // Running status
        p0 = pulses;
        send_seq('{8'h93, 8'h40, 8'h7F, 8'h40, 8'h00});
        chk("t2_pulses", pulses - p0, 4);
        chk("t2_ch", int'(bus.midi_ch), 3);
        chk("t2_db", int'(bus.databyte), 'h00);
        chk("t2_vel", int'(bus.is_velocity), 1);
        chk("t2_data", int'(bus.is_data_byte), 0);

        // Realtime interleave
        p0 = pulses;
        send_seq('{8'h80, 8'hF8, 8'h3C, 8'hFE});
        chk("t3_db_after_fe", int'(bus.databyte), 'h3C);
        chk("t3_data_after_fe", int'(bus.is_data_byte), 1);
        send_byte(8'h10);
        chk("t3_vel_db", int'(bus.databyte), 'h10);
        chk("t3_off", int'(bus.is_st_note_off), 1);
        chk("t3_pulses", pulses - p0, 2);

        // Sysex framing
        p0 = pulses;
        send_seq('{8'hF0, 8'h7E});
        chk("t4_sysex", int'(bus.is_st_sysex), 1);
        chk("t4_pos", int'({bus.is_data_byte, bus.is_velocity}), 0);
        send_seq('{8'h01, 8'hF7});
        chk("t4_sysex_end", int'(bus.is_st_sysex), 0);
        send_byte(8'h3C);
        chk("t4_discard_db", int'(bus.databyte), 'h01);
        chk("t4_pulses", pulses - p0, 2);

        // One-data-byte messages, then controller
        p0 = pulses;
        send_seq('{8'hC5, 8'h10, 8'h11});
        chk("t5_db", int'(bus.databyte), 'h11);
        chk("t5_data", int'(bus.is_data_byte), 1);
        chk("t5_vel", int'(bus.is_velocity), 0);
        chk("t5_st", int'({bus.is_st_note_on, bus.is_st_note_off, bus.is_st_ctrl}), 0);
        chk("t5_ch", int'(bus.midi_ch), 5);
        chk("t5_pulses", pulses - p0, 2);
        send_seq('{8'hB0, 8'h7B});
        chk("t5_ctrl", int'(bus.is_st_ctrl), 1);
        chk("t5_ctrl_data", int'(bus.is_data_byte), 1);
        send_byte(8'h00);
        chk("t5_ctrl_vel", int'(bus.is_velocity), 1);

        // Overrun burst then reset mid-pulse
        send_byte(8'h90);
        @(negedge CLOCK_25);
        check_en = 1'b0;
        bus.rx_data = 8'h3C; bus.rx_valid = 1'b1;
        @(negedge CLOCK_25);
        bus.rx_data = 8'h40;
        @(negedge CLOCK_25);
        bus.rx_data = 8'h50;
        @(negedge CLOCK_25);
        bus.rx_valid = 1'b0;
        chk("t6_overrun", int'(bus.rx_overrun), 1);
        chk("t6_br", int'(bus.byteready), 1);
        chk("t6_db", int'(bus.databyte), 'h3C);
        @(posedge CLOCK_25);
        #5 reset_reg_N = 1'b0;
        #1;
        chk("t6_rst_br", int'(bus.byteready), 0);
        chk("t6_rst_ovr", int'(bus.rx_overrun), 0);
        chk("t6_rst_all", int'(dut_vec()), 0);
        model_reset();
        repeat (2) @(posedge CLOCK_25);
        @(negedge CLOCK_25);
        reset_reg_N = 1'b1;
        check_en    = 1'b1;
        p0 = pulses;
        send_byte(8'h3C);
        chk("t6_no_status_pulses", pulses - p0, 0);
        chk("t6_no_status_db", int'(bus.databyte), 0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/midi_status_decoder.md
# midi_status_decoder

Front-end MIDI byte decoder that sits between the MIDI UART receiver and the note stack / controller handling logic. It accepts raw received bytes and tracks running status, system-exclusive framing and data-byte position. It presents each channel-voice data byte as a `byteready` pulse, with the qualifier flags (`is_st_note_on`, `is_data_byte`, `is_velocity`, …) that the note stack samples on the falling edge of `byteready`. Realtime bytes are filtered so they never disturb an in-progress message.

## Interface
Parameters:
- `BR_CYCLES`, 4: number of CLOCK_25 cycles `byteready` stays high per forwarded byte (valid range 1–255).

Ports:
- `CLOCK_25`  in  1  system clock.
- `reset_reg_N`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `byteready`  out  1  high for `BR_CYCLES` cycles per forwarded data byte.
- `databyte`  out  8  forwarded data byte; held until the next forwarded byte.
- `is_st_note_on`  out  1  running status is 9x.
- `is_st_note_off`  out  1  running status is 8x.
- `is_st_ctrl`  out  1  running status is Bx.
- `is_st_sysex`  out  1  inside an F0…F7 frame.
- `is_data_byte`  out  1  current `databyte` is the first data byte of a message.
- `is_velocity`  out  1  current `databyte` is the second data byte of a 2-data-byte message.
- `midi_ch`  out  4  channel nibble of the running status.
- `rx_overrun`  out  1  sticky flag: a byte was dropped because the pending register was full.

## Operation
- **Input buffer**: 1-entry pending register.
  - `rx_valid` with pending empty → load the byte.
  - `rx_valid` with pending full → drop the byte, set `rx_overrun`.
  - `rx_overrun` is cleared only by reset.
- **FSM states**: IDLE, STROBE, GAP.
  - IDLE with pending full: classify the byte and empty pending.
  - If the byte is forwarded → STROBE, with `byteready`=1 and the counter loaded with `BR_CYCLES`-1.
  - STROBE: decrement the counter; at 0 → GAP with `byteready`=0.
  - GAP: one cycle, then IDLE.
  - Non-forwarded bytes are absorbed in IDLE in a single cycle.
- **Classification**:
  - **80–EF (channel status)**:
    - Latch running status: `midi_ch` = low nibble; set exactly one of note_on / note_off / ctrl, or none for Ax, Cx, Dx, Ex.
    - Set `need2` = 0 for Cx and Dx, 1 otherwise.
    - Clear `dcnt`, `is_data_byte`, `is_velocity`, `is_st_sysex`.
    - No `byteready`.
  - **F0**: clear running status and all `is_st_*` flags; set `is_st_sysex`. No pulse.
  - **F7**: clear `is_st_sysex`; running status stays invalid. No pulse.
  - **F1–F6**: clear running status, all flags and `dcnt`. No pulse.
  - **F8–FF (realtime)**: ignored completely. Running status, `dcnt`, flags and outputs are unchanged. No pulse.
  - **00–7F inside sysex**: forward with `is_data_byte`=`is_velocity`=0 and `is_st_sysex`=1.
  - **00–7F with valid running status**:
    - `dcnt`=0 → `is_data_byte`=1, `is_velocity`=0. Then `dcnt`=`need2`.
    - `dcnt`=1 → `is_data_byte`=0, `is_velocity`=1. Then `dcnt`=0, which gives running-status repeat.
  - **00–7F with no running status**: discard. No pulse.
  - **Note-on with velocity 0**: forwarded unchanged, with `is_st_note_on` and `is_velocity`. The note stack handles it as a note-off.
- **Output update**: `databyte` and all flags update only in the cycle `byteready` rises, or on status bytes while `byteready` is low. They are never updated while `byteready`=1.

## Timing
- **Reset**: all outputs 0, running status invalid, `dcnt`=0, pending empty, state IDLE.
  - Reset asserted mid-STROBE drops `byteready` asynchronously. No partial message survives.
- **Latency**: `rx_valid` sampled at edge E0 → pending valid after E0 → `byteready` and outputs registered after E1.
  - `byteready` is high for exactly `BR_CYCLES` cycles and falls after edge E1+`BR_CYCLES`.
- **Flag stability**: `databyte` and flags are stable from the rising edge of `byteready` through at least 1 cycle after its falling edge.
- **Back-to-back throughput**: minimum spacing between forwarded bytes is `BR_CYCLES`+2 cycles.
  - A byte that arrives during STROBE/GAP waits in pending.
  - `rx_valid` in the same cycle that pending empties is accepted without overrun.
  - MIDI line rate (one byte per ~8000 cycles) never overruns.

## Test plan
- Send 90 3C 64 → two pulses, each 4 cycles wide.
  - First pulse: `databyte`=3C, `is_st_note_on`=1, `is_data_byte`=1, `midi_ch`=0.
  - Second pulse: `databyte`=64, `is_velocity`=1.
- Running status: 93 40 7F 40 00 → four pulses alternating data/velocity, `midi_ch`=3. Last pulse: `databyte`=00, `is_velocity`=1.
- Realtime interleave: 80 F8 3C FE 10 → exactly two pulses (3C data, 10 velocity) with `is_st_note_off`=1. F8 and FE produce no pulse and no flag change.
- Sysex framing: F0 7E 01 F7 3C.
  - Two pulses (7E, 01) with `is_st_sysex`=1 and both position flags 0.
  - After F7, `is_st_sysex`=0; 3C is discarded.
- One-data-byte messages: C5 10 11 → two pulses, both with `is_data_byte`=1, `is_velocity`=0, no `is_st_*` set, `midi_ch`=5.
  - Then B0 7B 00 → `is_st_ctrl`=1; pulses show 7B as data and 00 as velocity.
- Overrun and reset: `rx_valid` on 3 consecutive cycles → third byte dropped, `rx_overrun`=1.
  - Assert `reset_reg_N`=0 mid-pulse → `byteready`, `rx_overrun` and all flags go to 0 immediately.
  - After release, a data byte with no status is discarded.
